// File: rtl/dmem_port_arbiter.sv
// Shares RAM data port 1 between the CPU memory stage and the loader/debug master.
// CPU has priority; a wait counter forces a handoff to a starved loader, and a burst cap returns the port to the CPU.
module dmem_port_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 12,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [3:0]        cpu_wbe,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [3:0]        ld_wbe,
  input  logic [DWIDTH-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DWIDTH-1:0] ld_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_wbe,
  output logic [DWIDTH-1:0] mem_d,
  output logic              mem_wen,
  input  logic [DWIDTH-1:0] mem_q,
  output logic              owner_ld
);

  // state   | meaning
  // OWN_CPU | CPU drives the port; starve_cnt counts contended loader cycles
  // OWN_LD  | loader drives the port; burst_cnt counts back-to-back loader grants
  typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_t;

  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          sel_ld;
  logic          sel_req;
  logic          sel_we;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner      <= OWN_CPU;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      case (owner)
        OWN_CPU: begin
          if (ld_req) begin
            if (!cpu_req || starve_cnt == STARVE_LAST) begin
              owner      <= OWN_LD;
              starve_cnt <= '0;
              burst_cnt  <= '0;
            end else begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        OWN_LD: begin
          if (!ld_req || (cpu_req && burst_cnt == BURST_LAST)) begin
            owner     <= OWN_CPU;
            burst_cnt <= '0;
          end else if (burst_cnt != BURST_LAST) begin
            // saturating: an idle CPU lets the loader keep the port indefinitely
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: owner <= OWN_CPU;
      endcase
    end
  end

  assign owner_ld = (owner == OWN_LD);

  assign sel_ld   = (owner == OWN_LD);
  assign sel_req  = sel_ld ? ld_req : cpu_req;
  assign sel_we   = sel_ld ? ld_we  : cpu_we;

  assign mem_addr = sel_ld ? ld_addr  : cpu_addr;
  assign mem_d    = sel_ld ? ld_wdata : cpu_wdata;
  assign mem_wbe  = sel_req ? (sel_ld ? ld_wbe : cpu_wbe) : 4'b0000;

  // reset gates every strobe so an abandoned loader transfer cannot write
  assign mem_wen   = n_rst & sel_req & sel_we;
  assign cpu_stall = n_rst & sel_ld & cpu_req;
  assign ld_ack    = n_rst & sel_ld & ld_req;

  assign cpu_rdata = mem_q;
  assign ld_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and a shadow copy of the RAM.
module tb_dmem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int STARVE_LIMIT = 8;
  localparam int MAX_BURST = 16;

  logic          clk;
  logic          n_rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_wbe;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [3:0]    ld_wbe;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic          ld_ack;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wbe;
  logic [DW-1:0] mem_d, mem_q;
  logic          mem_wen;
  logic          owner_ld;

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  // reference model: who owns the port, contended cycles waited, acks in this tenure
  bit m_own_ld;
  int m_wait;
  int m_acks;

  logic          obs_ack, obs_stall, obs_own, obs_wen;
  logic [DW-1:0] obs_cpu_rdata;

  dmem_port_arbiter #(
    .DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wbe(cpu_wbe),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wbe(ld_wbe),
    .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wbe(mem_wbe), .mem_d(mem_d), .mem_wen(mem_wen),
    .mem_q(mem_q), .owner_ld(owner_ld)
  );

  assign mem_q = ram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input bit to_ram, input logic [AW-1:0] a, input logic [3:0] be,
                           input logic [DW-1:0] d);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        if (to_ram) ram[a][8*b +: 8] = d[8*b +: 8];
        else        shadow[a][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag);
    logic          req, we, exp_wen;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_wbe;
    logic [DW-1:0] exp_d;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_wbe;
    logic [DW-1:0] d_d;
    #2;
    if (!n_rst) begin
      m_own_ld = 1'b0;
      m_wait   = 0;
      m_acks   = 0;
    end
    req      = m_own_ld ? ld_req   : cpu_req;
    we       = m_own_ld ? ld_we    : cpu_we;
    exp_addr = m_own_ld ? ld_addr  : cpu_addr;
    exp_d    = m_own_ld ? ld_wdata : cpu_wdata;
    exp_wbe  = req ? (m_own_ld ? ld_wbe : cpu_wbe) : 4'b0000;
    exp_wen  = n_rst && req && we;
    check({tag, "_owner"}, 32'(owner_ld),  32'(m_own_ld));
    check({tag, "_stall"}, 32'(cpu_stall), 32'(n_rst && m_own_ld && cpu_req));
    check({tag, "_ack"},   32'(ld_ack),    32'(n_rst && m_own_ld && ld_req));
    check({tag, "_wen"},   32'(mem_wen),   32'(exp_wen));
    check({tag, "_addr"},  32'(mem_addr),  32'(exp_addr));
    check({tag, "_wbe"},   32'(mem_wbe),   32'(exp_wbe));
    check({tag, "_crd"},   cpu_rdata,      shadow[exp_addr]);
    check({tag, "_lrd"},   ld_rdata,       shadow[exp_addr]);
    if (exp_wen) check({tag, "_d"}, mem_d, exp_d);
    obs_ack = ld_ack; obs_stall = cpu_stall; obs_own = owner_ld; obs_wen = mem_wen;
    obs_cpu_rdata = cpu_rdata;
    d_wen = mem_wen; d_addr = mem_addr; d_wbe = mem_wbe; d_d = mem_d;
    @(posedge clk);
    if (d_wen)   write_mem(1'b1, d_addr, d_wbe, d_d);
    if (exp_wen) write_mem(1'b0, exp_addr, exp_wbe, exp_d);
    if (n_rst) begin
      if (!m_own_ld) begin
        if (ld_req && (!cpu_req || m_wait + 1 >= STARVE_LIMIT)) begin
          m_own_ld = 1'b1; m_wait = 0; m_acks = 0;
        end else if (ld_req) begin
          m_wait++;
        end else begin
          m_wait = 0;
        end
      end else begin
        if (!ld_req || (cpu_req && m_acks + 1 >= MAX_BURST)) begin
          m_own_ld = 1'b0; m_acks = 0;
        end else begin
          m_acks++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [3:0] be, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wbe = be; cpu_wdata = d;
  endtask

  task automatic drive_ld(input logic req, input logic we, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [DW-1:0] d);
    ld_req = req; ld_we = we; ld_addr = a; ld_wbe = be; ld_wdata = d;
  endtask

  initial begin
    int idx, acks, stalls, pc, pl;
    logic [DW-1:0] exp_word;
    bit done;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    m_own_ld = 1'b0; m_wait = 0; m_acks = 0;
    n_rst = 1'b0;
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    drive_ld(1'b0, 1'b0, '0, 4'h0, '0);
    @(negedge clk);

    // reset state, with requests present to show the strobes are forced off
    drive_ld(1'b1, 1'b1, 12'h005, 4'hF, 32'hFFFF_0000);
    step("rst0");
    step("rst1");
    n_rst = 1'b1;
    drive_ld(1'b0, 1'b0, '0, 4'h0, '0);

    // CPU write then read-back, loader idle
    drive_cpu(1'b1, 1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF);
    step("cpu_wr");
    check("cpu_wr_wen_seen", 32'(obs_wen), 32'd1);
    drive_cpu(1'b1, 1'b0, 12'h010, 4'h0, '0);
    step("cpu_rd");
    check("cpu_rd_data", obs_cpu_rdata, 32'hDEAD_BEEF);
    check("cpu_rd_nostall", 32'(obs_stall), 32'd0);

    // loader writes four words with the CPU idle
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    idx = 0;
    drive_ld(1'b1, 1'b1, 12'h000, 4'hF, 32'h11);
    step("ld_first");
    check("ld_first_noack", 32'(obs_ack), 32'd0);
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step("ld_wr");
      if (obs_ack) begin
        idx++;
        drive_ld(1'b1, 1'b1, AW'(idx), 4'hF, 32'(17 * (idx + 1)));
      end
    end
    check("ld_wr_count", 32'(idx), 32'd4);
    drive_ld(1'b0, 1'b0, '0, 4'h0, '0);
    step("ld_drop");
    check("ld_drop_owner_held", 32'(obs_own), 32'd1);
    step("ld_back");
    check("ld_back_owner", 32'(obs_own), 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_word = 32'(17 * (i + 1));
      check("ld_ram_word", ram[i], exp_word);
    end

    // starvation: CPU continuously requesting, loader forced in at cycle 8
    drive_cpu(1'b1, 1'b1, 12'h020, 4'hF, 32'hCAFE_0001);
    drive_ld(1'b1, 1'b0, 12'h010, 4'h0, '0);
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      step("starve");
      check("starve_cpu_served", 32'(obs_stall), 32'd0);
    end
    step("starve_hand");
    check("starve_owner", 32'(obs_own), 32'd1);
    check("starve_stall", 32'(obs_stall), 32'd1);
    check("starve_nowrite", 32'(obs_wen), 32'd0);

    // burst cap: fresh loader tenure, CPU arrives at its 4th grant
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    drive_ld(1'b0, 1'b0, '0, 4'h0, '0);
    step("idle");
    step("idle");
    drive_ld(1'b1, 1'b1, 12'h100, 4'hF, 32'h1000);
    acks = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step("burst");
      if (obs_ack) begin
        acks++;
        drive_ld(1'b1, 1'b1, AW'(12'h100 + acks), 4'hF, 32'(32'h1000 + acks));
        if (acks == 3) drive_cpu(1'b1, 1'b1, 12'h200, 4'h3, 32'h0000_ABCD);
      end else if (acks > 0 && !obs_own) begin
        done = 1'b1;
        check("burst_handoff_stall", 32'(obs_stall), 32'd0);
      end
    end
    check("burst_done", 32'(done), 32'd1);
    check("burst_acks", 32'(acks), 32'(MAX_BURST));

    // loader alone long enough to saturate, then a single-stall handoff
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    drive_ld(1'b0, 1'b0, '0, 4'h0, '0);
    step("idle");
    drive_ld(1'b1, 1'b0, 12'h001, 4'h0, '0);
    for (int c = 0; c < 40; c++) step("sat");
    drive_cpu(1'b1, 1'b0, 12'h010, 4'h0, '0);
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step("sat_cpu");
      if (obs_stall) stalls++;
      else done = 1'b1;
    end
    check("sat_stalls", 32'(stalls), 32'd1);
    check("sat_cpu_owner", 32'(obs_own), 32'd0);

    // reset in the middle of a loader write burst
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    drive_ld(1'b0, 1'b0, '0, 4'h0, '0);
    step("idle");
    drive_ld(1'b1, 1'b1, 12'h300, 4'hF, 32'h5555_AAAA);
    step("mid0");
    step("mid1");
    step("mid2");
    n_rst = 1'b0;
    step("mid_rst");
    check("mid_rst_wen", 32'(obs_wen), 32'd0);
    check("mid_rst_owner", 32'(obs_own), 32'd0);
    n_rst = 1'b1;
    drive_cpu(1'b1, 1'b1, 12'h040, 4'hF, 32'h0BAD_F00D);
    step("post_cpu");
    check("post_cpu_stall", 32'(obs_stall), 32'd0);
    check("post_cpu_wen", 32'(obs_wen), 32'd1);
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    step("post_ld0");
    check("post_ld0_ack", 32'(obs_ack), 32'd0);
    step("post_ld1");
    check("post_ld1_ack", 32'(obs_ack), 32'd1);

    // randomized traffic, request densities varied per phase
    pc = 50; pl = 50;
    for (int c = 0; c < 1200; c++) begin
      if (c % 60 == 0) begin
        pc = $urandom_range(100);
        pl = $urandom_range(100);
      end
      drive_cpu($urandom_range(99) < pc, 1'($urandom), AW'($urandom_range(15)),
                4'($urandom), $urandom);
      drive_ld($urandom_range(99) < pl, 1'($urandom), AW'($urandom_range(15)),
               4'($urandom), $urandom);
      if ($urandom_range(299) == 0) n_rst = 1'b0;
      step("rand");
      n_rst = 1'b1;
    end
    for (int i = 0; i < 16; i++) check("rand_ram", ram[i], shadow[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the data port (port 1) of the dual-port instruction/data RAM between two requesters.
- Requester 1 is the CPU memory stage; requester 2 is a loader/debug master (UART program loader) that reads and writes RAM while the core runs or is held.
- The CPU has priority. The loader is protected from starvation by a counter, and the CPU is protected by a burst limit.
- The RAM read is asynchronous; writes commit on the clock edge.

Parameters:
- DWIDTH, 32, data width.
- AWIDTH, 12, word-address width. Port addresses are word addresses.
- STARVE_LIMIT, 8, consecutive contended cycles the loader waits before a forced handoff. Must be ≥1.
- MAX_BURST, 16, loader accesses granted back-to-back before a pending CPU request reclaims the port. Must be ≥1.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request (M stage).
- cpu_we  in  1  CPU write.
- cpu_addr  in  AWIDTH  CPU word address.
- cpu_wbe  in  4  CPU byte enables.
- cpu_wdata  in  DWIDTH  CPU write data.
- cpu_rdata  out  DWIDTH  CPU read data, equal to mem_q.
- cpu_stall  out  1  CPU access not performed this cycle; CPU holds its request stable.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write.
- ld_addr  in  AWIDTH  loader word address.
- ld_wbe  in  4  loader byte enables.
- ld_wdata  in  DWIDTH  loader write data.
- ld_ack  out  1  loader access performed this cycle.
- ld_rdata  out  DWIDTH  loader read data, equal to mem_q.
- mem_addr  out  AWIDTH  to RAM addr1.
- mem_wbe  out  4  to RAM wbe1.
- mem_d  out  DWIDTH  to RAM d1.
- mem_wen  out  1  to RAM wen1.
- mem_q  in  DWIDTH  from RAM q1.
- owner_ld  out  1  registered owner: 0 = CPU, 1 = loader.

Behaviour:

State and reset:
- Registered state: owner (1 bit), starve_cnt (width clog2(STARVE_LIMIT)+1), burst_cnt (width clog2(MAX_BURST)+1).
- Asynchronous reset sets owner = 0 (CPU) and both counters to 0.
- While n_rst = 0: mem_wen = 0, cpu_stall = 0, ld_ack = 0 (combinationally forced). mem_addr, mem_wbe and mem_d follow the CPU inputs.
- Reset mid-burst abandons the loader transfer. The loader must re-request after reset.

Datapath mux (combinational on owner):
- owner = 0: mem_* = cpu_*, mem_wen = cpu_req & cpu_we, cpu_stall = 0, ld_ack = 0.
- owner = 1: mem_* = ld_*, mem_wen = ld_req & ld_we, ld_ack = ld_req, cpu_stall = cpu_req.
- A stalled or unacked request never writes.
- Read data is valid in the same cycle as the grant (async RAM).
- mem_wbe is masked to 0 when the selected requester has no request.

Transitions, owner = CPU:
- ld_req & !cpu_req → owner = 1 next cycle; starve_cnt = 0; burst_cnt = 0.
- ld_req & cpu_req & starve_cnt == STARVE_LIMIT-1 → owner = 1 next cycle (the CPU access this cycle completes); starve_cnt = 0; burst_cnt = 0.
- ld_req & cpu_req otherwise → starve_cnt + 1.
- !ld_req → starve_cnt = 0.

Transitions, owner = loader:
- !ld_req → owner = 0 next cycle; burst_cnt = 0.
- ld_req & cpu_req & burst_cnt == MAX_BURST-1 → owner = 0 next cycle (this loader access completes); burst_cnt = 0.
- ld_req otherwise → burst_cnt increments, saturating at MAX_BURST-1.
- Saturation means: with no CPU demand the loader keeps the port indefinitely. The first cpu_req after saturation costs exactly one stall cycle before handoff.

Latency and ordering:
- Handoff always costs one cycle. The first loader ack comes one cycle after ld_req is seen by an idle CPU-owned port.
- Each acked cycle is one complete access. The loader advances its address on ld_ack.

Test Plan:
- Reset, then CPU write addr 0x010, data 0xDEADBEEF, wbe 0xF, with ld_req = 0 → mem_wen = 1 that cycle; next-cycle read of 0x010 returns 0xDEADBEEF; cpu_stall stays 0.
- CPU idle, loader writes 0x000..0x003 with data 0x11..0x44 → owner_ld = 1 from cycle 1; ld_ack on cycles 1–4; owner returns to 0 the cycle after ld_req drops; RAM holds the four words.
- cpu_req held continuously, ld_req asserted at cycle 0, STARVE_LIMIT = 8 → CPU accesses on cycles 0–7, owner_ld = 1 at cycle 8, cpu_stall = 1 at cycle 8, and no CPU write occurs at cycle 8.
- Loader owns the port with continuous ld_req, cpu_req asserted from cycle 3 of the burst, MAX_BURST = 16 → exactly 16 ld_acks, then owner = 0; cpu_stall is high for the preceding cycles and drops on the handoff cycle.
- Loader alone for 40 cycles, then cpu_req → stall for 1 cycle, then CPU granted.
- n_rst pulled low mid-burst with ld_req = 1, ld_we = 1 → mem_wen = 0 immediately, owner_ld = 0; after release the CPU gets its first access with no stall; the loader is re-granted one cycle after it is seen while the CPU is idle.
